// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, pixel coordinates,
// line/frame/vblank strobes and a look-ahead fetch coordinate for pipelined RAM reads.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FETCH_LEAD = 2,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          h_sync_o,
  output logic          v_sync_o,
  output logic          active,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("vga_timing_gen: active, porch and sync parameters must all be non-zero");
  end
  if (FETCH_LEAD < 0 || FETCH_LEAD > H_FP + H_SYNC + H_BP) begin : g_bad_lead
    $error("vga_timing_gen: FETCH_LEAD outside 0..H_FP+H_SYNC+H_BP");
  end
  if (CW < 2 || CW > 30 || (H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for the line or frame totals");
  end

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SB    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SB    = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE    = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0]   F_LEAD  = (CW+1)'(FETCH_LEAD);
  localparam logic [CW:0]   H_TOT_W = (CW+1)'(H_TOTAL);

  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic          h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic          active_q, active_d;
  logic [CW-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic [CW-1:0] fetch_x_q, fetch_x_d, fetch_y_q, fetch_y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          vblank_start_q, vblank_start_d;

  logic [CW-1:0] h_nxt, v_nxt, fh_nxt, fv_nxt;
  logic [CW:0]   fh_sum;
  logic          fh_wrap, act_nxt, fvalid_nxt;

  always_comb begin
    h_nxt = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    v_nxt = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_nxt = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
    // Look-ahead never exceeds one blanking interval, so a single wrap suffices.
    fh_sum  = {1'b0, h_nxt} + F_LEAD;
    fh_wrap = (fh_sum >= H_TOT_W);
    fh_nxt  = fh_wrap ? CW'(fh_sum - H_TOT_W) : fh_sum[CW-1:0];
    fv_nxt  = v_nxt;
    if (fh_wrap) begin
      fv_nxt = (v_nxt == V_LAST) ? '0 : v_nxt + 1'b1;
    end
    act_nxt    = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    fvalid_nxt = (fh_nxt < H_ACT) && (fv_nxt < V_ACT);
  end

  always_comb begin
    h_cnt_d        = h_cnt_q;
    v_cnt_d        = v_cnt_q;
    h_sync_d       = h_sync_q;
    v_sync_d       = v_sync_q;
    active_d       = active_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    fetch_valid_d  = fetch_valid_q;
    fetch_x_d      = fetch_x_q;
    fetch_y_d      = fetch_y_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    vblank_start_d = 1'b0;
    if (en) begin
      h_cnt_d        = h_nxt;
      v_cnt_d        = v_nxt;
      h_sync_d       = (h_nxt >= H_SB && h_nxt < H_SE) ? HS_POL : ~HS_POL;
      v_sync_d       = (v_nxt >= V_SB && v_nxt < V_SE) ? VS_POL : ~VS_POL;
      active_d       = act_nxt;
      pos_x_d        = act_nxt ? h_nxt : '0;
      pos_y_d        = act_nxt ? v_nxt : '0;
      fetch_valid_d  = fvalid_nxt;
      fetch_x_d      = fvalid_nxt ? fh_nxt : '0;
      fetch_y_d      = fvalid_nxt ? fv_nxt : '0;
      line_start_d   = (h_nxt == '0);
      frame_start_d  = (h_nxt == '0) && (v_nxt == '0);
      vblank_start_d = (h_nxt == '0) && (v_nxt == V_ACT);
    end
  end

  // Reset parks the counters on the last pixel so the first enabled edge shows (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q        <= H_LAST;
      v_cnt_q        <= V_LAST;
      h_sync_q       <= ~HS_POL;
      v_sync_q       <= ~VS_POL;
      active_q       <= 1'b0;
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      fetch_valid_q  <= 1'b0;
      fetch_x_q      <= '0;
      fetch_y_q      <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      h_sync_q       <= h_sync_d;
      v_sync_q       <= v_sync_d;
      active_q       <= active_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      fetch_valid_q  <= fetch_valid_d;
      fetch_x_q      <= fetch_x_d;
      fetch_y_q      <= fetch_y_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign h_sync_o     = h_sync_q;
  assign v_sync_o     = v_sync_q;
  assign active       = active_q;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign fetch_valid  = fetch_valid_q;
  assign fetch_x      = fetch_x_q;
  assign fetch_y      = fetch_y_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule
